// File: rtl/irq_controller_if.sv
// CPU-side bus and interrupt handshake bundle for irq_controller.
// master = CPU, slave = interrupt controller.
interface irq_controller_if;
   logic [23:0] address_in;
   logic [7:0]  data_in;
   logic [1:0]  bus_status;
   logic        write;
   logic        read;
   logic        iack;
   logic [7:0]  data_out;
   logic        data_oe;
   logic        irq_req;
   logic [1:0]  irq_level;
   logic [3:0]  irq_vector;

   modport master (
      output address_in, data_in, bus_status, write, read, iack,
      input  data_out, data_oe, irq_req, irq_level, irq_vector
   );

   modport slave (
      input  address_in, data_in, bus_status, write, read, iack,
      output data_out, data_oe, irq_req, irq_level, irq_vector
   );
endinterface

// File: rtl/irq_controller.sv
// 16-source interrupt controller for the s1c88 bus: synchronised edge capture,
// per-source enables, per-group priorities, and an iack handshake.
module irq_controller #(
   parameter logic [23:0] BASE_ADDR   = 24'h002020,
   parameter int          SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset,
   irq_controller_if.slave bus,
   input  logic [15:0]     irq_src
);

   typedef enum logic {IDLE, ACK} state_t;

   localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][15:0] sync_p;
   logic [15:0]                  prev_p;
   logic [ARM_W-1:0]             arm_cnt;
   logic                         armed;
   logic [15:0]                  pri;
   logic [15:0]                  ena;
   logic [15:0]                  flag;
   state_t                       state;
   logic                         iack_q;
   logic [3:0]                   vec_hold;
   logic [7:0]                   rd_data;
   logic                         rd_vld;

   logic                         sel;
   logic [3:0]                   off;
   logic                         wr_en;
   logic                         rd_en;
   logic                         ack_start;
   logic [15:0]                  rise;
   logic [15:0]                  w1c;
   logic [15:0]                  ack_clr;
   logic [1:0]                   win_lvl;
   logic [3:0]                   win_idx;
   logic [1:0]                   lvl;

   function automatic logic [1:0] group_pri(input logic [15:0] pri_all, input int src);
      return pri_all[2*(src/2) +: 2];
   endfunction

   function automatic logic [7:0] reg_read(input logic [3:0] o, input logic [15:0] p,
                                           input logic [15:0] e, input logic [15:0] f);
      case (o)
         4'd0:    return p[7:0];
         4'd1:    return p[15:8];
         4'd2:    return e[7:0];
         4'd3:    return e[15:8];
         4'd4:    return f[7:0];
         4'd5:    return f[15:8];
         default: return 8'hFF;
      endcase
   endfunction

   assign sel       = (bus.address_in[23:4] == BASE_ADDR[23:4]);
   assign off       = bus.address_in[3:0];
   assign wr_en     = bus.write && (bus.bus_status == 2'd2) && sel;
   assign rd_en     = bus.read  && (bus.bus_status == 2'd3) && sel;
   assign ack_start = (state == IDLE) && bus.iack && !iack_q;

   // Edges are suppressed until the sync chain and prev flop hold real samples,
   // so a source already high at reset release is not mistaken for a new edge.
   assign armed = (arm_cnt == ARM_DONE);
   assign rise  = sync_p[SYNC_STAGES-1] & ~prev_p & {16{armed}};

   always_comb begin
      w1c = '0;
      if (wr_en && off == 4'd4) w1c[7:0]  = bus.data_in;
      if (wr_en && off == 4'd5) w1c[15:8] = bus.data_in;
   end

   // Strict greater-than keeps the lowest index on equal priority.
   always_comb begin
      win_lvl = '0;
      win_idx = '0;
      lvl     = '0;
      for (int i = 0; i < 16; i++) begin
         lvl = group_pri(pri, i);
         if (flag[i] && ena[i] && lvl > win_lvl) begin
            win_lvl = lvl;
            win_idx = 4'(i);
         end
      end
   end

   assign ack_clr = (ack_start && win_lvl != 2'd0) ? (16'd1 << win_idx) : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p   <= '0;
         prev_p   <= '0;
         arm_cnt  <= '0;
         pri      <= '0;
         ena      <= '0;
         flag     <= '0;
         state    <= IDLE;
         iack_q   <= 1'b0;
         vec_hold <= '0;
         rd_data  <= '0;
         rd_vld   <= 1'b0;
      end else begin
         sync_p <= {sync_p[SYNC_STAGES-2:0], irq_src};
         prev_p <= sync_p[SYNC_STAGES-1];
         if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);

         if (wr_en) begin
            case (off)
               4'd0:    pri[7:0]  <= bus.data_in;
               4'd1:    pri[15:8] <= bus.data_in;
               4'd2:    ena[7:0]  <= bus.data_in;
               4'd3:    ena[15:8] <= bus.data_in;
               default: ;
            endcase
         end

         // A new edge overrides any clear of the same bit.
         flag   <= (flag & ~w1c & ~ack_clr) | rise;
         iack_q <= bus.iack;

         case (state)
            IDLE: if (ack_start) begin
               state    <= ACK;
               vec_hold <= win_idx;
            end
            ACK:  if (!bus.iack) state <= IDLE;
            default: state <= IDLE;
         endcase

         rd_vld <= rd_en;
         if (rd_en) rd_data <= reg_read(off, pri, ena, flag);
      end
   end

   assign bus.data_out   = rd_data;
   assign bus.data_oe    = rd_vld;
   assign bus.irq_req    = (win_lvl != 2'd0);
   assign bus.irq_level  = win_lvl;
   assign bus.irq_vector = (state == ACK) ? vec_hold : win_idx;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus randomized traffic checked
// against a register/flag-level reference model.
module tb_irq_controller;
   localparam logic [23:0] BASE = 24'h002020;
   localparam int          SYNC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] irq_src;

   irq_controller_if bus();

   irq_controller #(.BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .reset(reset), .bus(bus), .irq_src(irq_src)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [15:0] m_pri, m_ena, m_flag;
   logic [15:0] s1, s2, s3;
   logic [7:0]  m_dout;
   logic        m_doe, m_in_ack, m_iack_prev, m_hit;
   logic [3:0]  m_vec_hold;
   int          m_edges;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_pri = '0; m_ena = '0; m_flag = '0;
      s1 = '0; s2 = '0; s3 = '0;
      m_dout = '0; m_doe = 1'b0; m_in_ack = 1'b0; m_iack_prev = 1'b0;
      m_vec_hold = '0; m_edges = 0;
   endtask

   // Highest priority level first, lowest index within a level.
   task automatic m_winner(output logic [1:0] lvl, output logic [3:0] idx);
      bit found = 0;
      lvl = '0; idx = '0;
      for (int p = 3; p >= 1; p--)
         for (int i = 0; i < 16; i++)
            if (!found && m_flag[i] && m_ena[i] && m_pri[2*(i/2) +: 2] == 2'(p)) begin
               found = 1; lvl = 2'(p); idx = 4'(i);
            end
   endtask

   function automatic logic [7:0] m_reg(input logic [3:0] o);
      case (o)
         4'd0: return m_pri[7:0];
         4'd1: return m_pri[15:8];
         4'd2: return m_ena[7:0];
         4'd3: return m_ena[15:8];
         4'd4: return m_flag[7:0];
         4'd5: return m_flag[15:8];
         default: return 8'hFF;
      endcase
   endfunction

   task automatic drive(input logic [1:0] st, input logic wr, input logic rd,
                        input logic [3:0] off, input logic [7:0] d, input logic hit);
      bus.bus_status = st; bus.write = wr; bus.read = rd; bus.data_in = d;
      bus.address_in = hit ? {BASE[23:4], off} : {BASE[23:4] ^ 20'h00010, off};
      m_hit = hit;
   endtask

   task automatic idle();
      drive(2'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
   endtask

   // One clock: advance the model on the edge, then compare 1 time unit later.
   task automatic cycle();
      logic [1:0] wl;
      logic [3:0] wi;
      logic [15:0] set, clr;
      logic wr, rd;
      logic [3:0] o;
      @(posedge clk);
      m_winner(wl, wi);
      o   = bus.address_in[3:0];
      wr  = bus.write && bus.bus_status == 2'd2 && m_hit;
      rd  = bus.read  && bus.bus_status == 2'd3 && m_hit;
      set = (m_edges >= SYNC + 1) ? (s2 & ~s3) : 16'h0;
      clr = '0;
      if (rd) begin m_dout = m_reg(o); m_doe = 1'b1; end
      else m_doe = 1'b0;
      if (wr) begin
         case (o)
            4'd0: m_pri[7:0]  = bus.data_in;
            4'd1: m_pri[15:8] = bus.data_in;
            4'd2: m_ena[7:0]  = bus.data_in;
            4'd3: m_ena[15:8] = bus.data_in;
            4'd4: clr[7:0]    = bus.data_in;
            4'd5: clr[15:8]   = bus.data_in;
            default: ;
         endcase
      end
      if (!m_in_ack && bus.iack && !m_iack_prev) begin
         m_in_ack = 1'b1;
         m_vec_hold = wi;
         if (wl != 2'd0) clr[wi] = 1'b1;
      end else if (m_in_ack && !bus.iack) begin
         m_in_ack = 1'b0;
      end
      m_flag = (m_flag & ~clr) | set;
      m_iack_prev = bus.iack;
      s3 = s2; s2 = s1; s1 = irq_src;
      if (m_edges < 100) m_edges++;
      #1;
      m_winner(wl, wi);
      chk("irq_req",    16'(bus.irq_req),    16'(wl != 2'd0));
      chk("irq_level",  16'(bus.irq_level),  16'(wl));
      chk("irq_vector", 16'(bus.irq_vector), 16'(m_in_ack ? m_vec_hold : wi));
      chk("data_oe",    16'(bus.data_oe),    16'(m_doe));
      chk("data_out",   16'(bus.data_out),   16'(m_dout));
   endtask

   task automatic wr_reg(input logic [3:0] off, input logic [7:0] d);
      drive(2'd2, 1'b1, 1'b0, off, d, 1'b1);
      cycle();
      idle();
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] off, input logic [7:0] exp);
      drive(2'd3, 1'b0, 1'b1, off, 8'h00, 1'b1);
      cycle();
      chk(tag, 16'(bus.data_out), 16'(exp));
      chk({tag, "_oe"}, 16'(bus.data_oe), 16'h1);
      idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] roff;
      logic [7:0] rdat;
      logic       rhit;
      int unsigned r;

      reset = 1'b0; irq_src = '0; bus.iack = 1'b0;
      idle();
      m_reset();
      #1;
      chk("rst_irq_req",    16'(bus.irq_req),    16'h0);
      chk("rst_irq_vector", 16'(bus.irq_vector), 16'h0);
      chk("rst_data_oe",    16'(bus.data_oe),    16'h0);
      chk("rst_data_out",   16'(bus.data_out),   16'h0);
      #11 reset = 1'b1;

      // Reset values of the window, including an unmapped offset.
      for (int i = 0; i < 6; i++) rd_chk("rst_reg", 4'(i), 8'h00);
      rd_chk("unmapped_6", 4'd6, 8'hFF);
      cycle();
      chk("oe_drop", 16'(bus.data_oe), 16'h0);

      // Single source, three-edge capture latency.
      wr_reg(4'd0, 8'h03);
      wr_reg(4'd2, 8'h01);
      irq_src[0] = 1'b1; cycle();
      irq_src[0] = 1'b0; cycle();
      chk("lat_early_req", 16'(bus.irq_req), 16'h0);
      cycle();
      chk("lat_req",    16'(bus.irq_req),    16'h1);
      chk("lat_level",  16'(bus.irq_level),  16'h3);
      chk("lat_vector", 16'(bus.irq_vector), 16'h0);
      rd_chk("flag0_set", 4'd4, 8'h01);
      wr_reg(4'd4, 8'h01);

      // Two sources at different priorities, then an acknowledge.
      wr_reg(4'd0, 8'h0C);
      wr_reg(4'd1, 8'h01);
      wr_reg(4'd2, 8'h04);
      wr_reg(4'd3, 8'h01);
      irq_src = 16'h0104; cycle();
      irq_src = 16'h0000; cycle(); cycle();
      chk("arb_level",  16'(bus.irq_level),  16'h3);
      chk("arb_vector", 16'(bus.irq_vector), 16'h2);
      bus.iack = 1'b1; cycle();
      chk("ack_vector", 16'(bus.irq_vector), 16'h2);
      chk("ack_level",  16'(bus.irq_level),  16'h1);
      rd_chk("ack_flag0", 4'd4, 8'h00);
      chk("ack_frozen", 16'(bus.irq_vector), 16'h2);
      bus.iack = 1'b0; cycle();
      chk("post_ack_vector", 16'(bus.irq_vector), 16'h8);
      wr_reg(4'd5, 8'h01);

      // Set beats a simultaneous write-1-to-clear.
      irq_src[0] = 1'b1; cycle();
      irq_src[0] = 1'b0; cycle();
      drive(2'd2, 1'b1, 1'b0, 4'd4, 8'h01, 1'b1);
      cycle();
      idle();
      rd_chk("set_wins", 4'd4, 8'h01);
      wr_reg(4'd4, 8'h01);
      rd_chk("w1c_alone", 4'd4, 8'h00);

      // Spurious acknowledge.
      bus.iack = 1'b1; cycle();
      chk("spur_vector", 16'(bus.irq_vector), 16'h0);
      chk("spur_req",    16'(bus.irq_req),    16'h0);
      rd_chk("spur_flag0", 4'd4, 8'h00);
      rd_chk("spur_flag1", 4'd5, 8'h00);
      bus.iack = 1'b0; cycle();

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         r = $urandom_range(0, 9);
         irq_src = irq_src ^ 16'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 5) == 0) bus.iack = ~bus.iack;
         roff = 4'($urandom_range(0, 7));
         rdat = 8'($urandom);
         rhit = ($urandom_range(0, 7) != 0);
         if (r < 3)
            drive(($urandom_range(0, 7) == 0) ? 2'd3 : 2'd2, 1'b1, 1'b0, roff, rdat, rhit);
         else if (r < 6)
            drive(($urandom_range(0, 7) == 0) ? 2'd2 : 2'd3, 1'b0, 1'b1, roff, rdat, rhit);
         else
            idle();
         cycle();
      end
      irq_src = '0; bus.iack = 1'b0; idle();
      repeat (4) cycle();

      // Asynchronous reset in the middle of an acknowledge.
      wr_reg(4'd0, 8'hFF);
      wr_reg(4'd2, 8'hFF);
      irq_src = 16'h0003; cycle();
      irq_src = 16'h0000; cycle(); cycle();
      bus.iack = 1'b1; cycle();
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_req",    16'(bus.irq_req),    16'h0);
      chk("mid_rst_level",  16'(bus.irq_level),  16'h0);
      chk("mid_rst_vector", 16'(bus.irq_vector), 16'h0);
      chk("mid_rst_oe",     16'(bus.data_oe),    16'h0);
      m_reset();
      irq_src = 16'hFFFF; bus.iack = 1'b0; idle();
      #2 reset = 1'b1;
      repeat (8) cycle();
      for (int i = 0; i < 6; i++) rd_chk("post_rst_reg", 4'(i), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Interrupt controller on the s1c88 system bus. Synchronises and edge-detects 16 peripheral interrupt sources, latches them as pending flags, and applies per-source enables and per-group 2-bit priorities. It presents the winning request (level + vector) to the CPU and services the CPU's iack handshake. It exposes a 6-byte register window on the CPU bus.

Parameters:
BASE_ADDR, 24'h002020, base address of the register window; must be 16-byte aligned.
SYNC_STAGES, 2, flip-flop stages on each irq_src bit before edge detection; minimum 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
address_in  input  24  CPU address_out
data_in  input  8  CPU write data (CPU data_out)
bus_status  input  2  CPU bus command: 0 idle, 1 irq read, 2 mem write, 3 mem read
write  input  1  CPU write strobe
read  input  1  CPU read strobe
iack  input  1  CPU interrupt acknowledge, level
irq_src  input  16  peripheral interrupt lines, asynchronous, active-high
data_out  output  8  register read data
data_oe  output  1  data_out valid; drives the CPU read mux
irq_req  output  1  a pending, enabled, nonzero-priority source exists
irq_level  output  2  priority of the winning source; 0 when irq_req=0
irq_vector  output  4  winning source index; frozen while iack=1

Behaviour:
- Register select: sel = (address_in[23:4] == BASE_ADDR[23:4]); off = address_in[3:0].
- Register map:
  - off 0 PRI0: bits [2g+1:2g] = priority of group g, g=0..3.
  - off 1 PRI1: the same layout for groups 4..7.
  - Source i belongs to group i>>1.
  - off 2 ENA0: enables for sources 7..0. off 3 ENA1: enables for sources 15..8.
  - off 4 FLAG0: pending flags for sources 7..0. off 5 FLAG1: pending flags for sources 15..8.
  - FLAG registers are write-1-to-clear.
  - off 6..15: reads return 8'hFF; writes are ignored.
- Write: on the rising clk edge where write=1, bus_status=2 and sel=1, the addressed register updates.
- Read: on the rising edge where read=1, bus_status=3 and sel=1, data_out <= register value and data_oe <= 1. Otherwise data_oe <= 0 and data_out holds its last value.
  - Read latency is 1 cycle.
- Source capture: each irq_src bit passes through SYNC_STAGES flops, then a rising-edge detector. The edge sets the flag.
  - With the default parameter, the flag is visible 3 clk edges after irq_src rises.
  - Levels held high do not re-set a flag after it is cleared.
- Arbitration (combinational from registered state):
  - Candidate i = flag[i] & ena[i] & (pri[i>>1] != 0).
  - Winner = the candidate with the highest priority; ties go to the lowest index.
  - irq_req = any candidate. irq_level = winner priority. irq_vector = winner index.
  - With no candidates, irq_level=0 and irq_vector=0.
- iack handshake, states IDLE -> ACK -> IDLE:
  - IDLE: iack is sampled rising (0 then 1) and the current winner is captured into vec_hold.
    - If a winner exists, its flag is cleared in that same cycle.
    - If none exists, vec_hold=0 and no flag changes (spurious acknowledge).
    - Go to ACK.
  - ACK: irq_vector = vec_hold, frozen. irq_req and irq_level keep tracking the remaining candidates.
    - On iack=0, return to IDLE.
- Simultaneous events: a set always wins over a clear.
  - An edge on source i in the same cycle as a W1C or iack-clear of flag i leaves flag i = 1.
  - A W1C write and an iack clear of different bits in the same cycle both take effect.
- Reset (asynchronous, any time, including mid-ACK):
  - All PRI, ENA and FLAG registers are 0; the sync and edge flops are 0; the FSM goes to IDLE; vec_hold=0.
  - Outputs: data_out=8'h00, data_oe=0, irq_req=0, irq_level=0, irq_vector=0.
  - A source that is high when reset deasserts does not produce an edge (its sync chain starts at 0 but is filled before edge detection is enabled: the edge detector's previous-value flop loads from the last sync stage starting on the first edge after reset).

Test Plan:
- Reset then read off 0..5 and 6 -> data_out 00,00,00,00,00,00,FF, with data_oe pulsing 1 cycle after each read strobe.
- Write PRI0=8'h03 (group 0 = 3) and ENA0=8'h01, then pulse irq_src[0] -> FLAG0=01 three cycles after the rise; irq_req=1, irq_level=3, irq_vector=0.
- PRI0=8'h0C (group 1 = 3), PRI1=8'h01 (group 4 = 1), ENA0=8'h04, ENA1=8'h01; pulse sources 2 and 8 together -> irq_level=3, irq_vector=2.
  - Then raise iack -> FLAG0=00; irq_vector stays 2 while iack=1; irq_level=1.
  - Drop iack -> irq_vector=8.
- Write FLAG0=8'h01 in the same cycle as a detected edge on source 0 -> FLAG0 reads 01. A later write without an edge -> FLAG0 reads 00.
- Raise iack with no candidates -> irq_vector=0, flags unchanged, irq_req=0.
- Assert reset during ACK with flags set -> all registers 0, irq_req=0. After release, holding irq_src high does not set any flag.
